// File: rtl/if_id_stage_if.sv
// Fetch <-> IF/ID interface: instruction/next-PC from fetch, jump redirect back to fetch.
interface if_id_stage_if #(
    parameter int INSTR_W = 20,
    parameter int ADDR_W  = 8
);
    logic [INSTR_W-1:0] instructionwire;
    logic [ADDR_W-1:0]  npc;
    logic               jump_selector;
    logic [ADDR_W-1:0]  jump_address;

    modport master (output instructionwire, npc, input jump_selector, jump_address);
    modport slave  (input instructionwire, npc, output jump_selector, jump_address);
endinterface

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with jump resolver and one-bubble squash.
// Optional IF_ID_JUMP_STATS_EN adds saturating jump/squash/valid counters.
//
// state  | meaning
// BOOT   | first edge after reset; captured word is fetch's pre-start output, never valid
// RUN    | captured word is valid and decoded for JMP/JREL/HALT
// SQUASH | captured word is the wrong-path successor of a jump; invalid, not decoded
// HALTED | HALT retired; IR frozen until reset
module if_id_stage #(
    parameter int         INSTR_W  = 20,
    parameter int         ADDR_W   = 8,
    parameter logic [3:0] OPC_JMP  = 4'b1100,
    parameter logic [3:0] OPC_JREL = 4'b1101,
    parameter logic [3:0] OPC_HALT = 4'b1111
) (
    input  logic               clkwire,
    input  logic               rstwire_n,
    if_id_stage_if.slave       fetch,
    output logic               id_valid,
    output logic [INSTR_W-1:0] id_instruction,
    output logic [ADDR_W-1:0]  id_npc,
    output logic [3:0]         id_opcode,
    output logic [3:0]         id_r1,
    output logic [3:0]         id_r2,
    output logic [7:0]         id_imm,
`ifdef IF_ID_JUMP_STATS_EN
    output logic [15:0]        jump_count,
    output logic [15:0]        squash_count,
    output logic [15:0]        valid_count,
`endif
    output logic               halted
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        SQUASH = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                valid_q, valid_d;
    logic                jsel_q, jsel_d;
    logic [ADDR_W-1:0]   jaddr_q, jaddr_d;
    logic                halted_q, halted_d;
    logic [INSTR_W-1:0]  instr_q;
    logic [ADDR_W-1:0]   npc_q;
    logic                capture;
    logic                taken;

    logic [3:0]          in_opc;
    logic [7:0]          in_imm;
    logic signed [7:0]   in_imm_s;
    logic [ADDR_W-1:0]   imm_sx;

    // Decode looks at the word being captured this edge, not the one already in IR.
    assign in_opc   = fetch.instructionwire[INSTR_W-1 -: 4];
    assign in_imm   = fetch.instructionwire[7:0];
    assign in_imm_s = signed'(in_imm);
    assign imm_sx   = ADDR_W'(in_imm_s);

    always_comb begin
        state_d  = state_q;
        capture  = 1'b1;
        valid_d  = 1'b0;
        jsel_d   = 1'b0;
        jaddr_d  = jaddr_q;
        halted_d = halted_q;
        taken    = 1'b0;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                valid_d = 1'b1;
                if (in_opc == OPC_JMP) begin
                    taken   = 1'b1;
                    jaddr_d = ADDR_W'(in_imm);
                    state_d = SQUASH;
                end else if (in_opc == OPC_JREL) begin
                    taken   = 1'b1;
                    jaddr_d = fetch.npc + imm_sx;
                    state_d = SQUASH;
                end else if (in_opc == OPC_HALT) begin
                    halted_d = 1'b1;
                    state_d  = HALTED;
                end
                jsel_d = taken;
            end
            SQUASH: state_d = RUN;
            HALTED: capture = 1'b0;
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clkwire or negedge rstwire_n) begin
        if (!rstwire_n) begin
            state_q  <= BOOT;
            valid_q  <= 1'b0;
            jsel_q   <= 1'b0;
            jaddr_q  <= '0;
            halted_q <= 1'b0;
            instr_q  <= '0;
            npc_q    <= '0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            jsel_q   <= jsel_d;
            jaddr_q  <= jaddr_d;
            halted_q <= halted_d;
            if (capture) begin
                instr_q <= fetch.instructionwire;
                npc_q   <= fetch.npc;
            end
        end
    end

    assign fetch.jump_selector = jsel_q;
    assign fetch.jump_address  = jaddr_q;
    assign id_valid       = valid_q;
    assign id_instruction = instr_q;
    assign id_npc         = npc_q;
    assign id_opcode      = instr_q[INSTR_W-1 -: 4];
    assign id_r1          = instr_q[INSTR_W-5 -: 4];
    assign id_r2          = instr_q[INSTR_W-9 -: 4];
    assign id_imm         = instr_q[7:0];
    assign halted         = halted_q;

`ifdef IF_ID_JUMP_STATS_EN
    logic [15:0] jcnt_q, scnt_q, vcnt_q;

    always_ff @(posedge clkwire or negedge rstwire_n) begin
        if (!rstwire_n) begin
            jcnt_q <= '0;
            scnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            if (taken && jcnt_q != 16'hFFFF)
                jcnt_q <= jcnt_q + 16'd1;
            if (state_q == SQUASH && scnt_q != 16'hFFFF)
                scnt_q <= scnt_q + 16'd1;
            if (valid_d && vcnt_q != 16'hFFFF)
                vcnt_q <= vcnt_q + 16'd1;
        end
    end

    assign jump_count   = jcnt_q;
    assign squash_count = scnt_q;
    assign valid_count  = vcnt_q;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage with a tiny fetch model that honours the redirect.
module tb_if_id_stage;
    logic       clk;
    logic       rstwire_n;
    logic       id_valid, halted;
    logic [19:0] id_instruction;
    logic [7:0]  id_npc, id_imm;
    logic [3:0]  id_opcode, id_r1, id_r2;
`ifdef IF_ID_JUMP_STATS_EN
    logic [15:0] jump_count, squash_count, valid_count;
`endif

    if_id_stage_if #(.INSTR_W(20), .ADDR_W(8)) fif ();

    if_id_stage dut (
        .clkwire        (clk),
        .rstwire_n      (rstwire_n),
        .fetch          (fif),
        .id_valid       (id_valid),
        .id_instruction (id_instruction),
        .id_npc         (id_npc),
        .id_opcode      (id_opcode),
        .id_r1          (id_r1),
        .id_r2          (id_r2),
        .id_imm         (id_imm),
`ifdef IF_ID_JUMP_STATS_EN
        .jump_count     (jump_count),
        .squash_count   (squash_count),
        .valid_count    (valid_count),
`endif
        .halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [19:0] imem [256];
    logic [7:0]  pc;
    logic        prev_js;
    int          checks = 0;
    int          errors = 0;
    int          pulses;
    int          vcount;

    task automatic do_reset();
        rstwire_n = 1'b0;
        for (int i = 0; i < 256; i++) imem[i] = {4'h0, 4'h3, 4'h5, 8'(i)};
        pc = 8'hFF;
        fif.instructionwire = 20'hC0055;   // junk JMP before first edge: must be ignored
        fif.npc = 8'hAA;
        prev_js = 1'b0;
        pulses = 0;
        vcount = 0;
        repeat (2) @(negedge clk);
        rstwire_n = 1'b1;
    endtask

    // One clock: fetch samples the redirect registered before this edge.
    task automatic step();
        logic       js;
        logic [7:0] ja;
        js = fif.jump_selector;
        ja = fif.jump_address;
        @(posedge clk);
        #1;
        checks++;
        if (fif.jump_selector && prev_js) begin
            errors++;
            $display("FAIL js_consecutive got 1 want 0 at t=%0t", $time);
        end
        if (fif.jump_selector) pulses++;
        if (id_valid) vcount++;
        prev_js = fif.jump_selector;
        pc = js ? ja : pc + 8'd1;
        fif.instructionwire = imem[pc];
        fif.npc = pc + 8'd1;
    endtask

    task automatic test_reset();
        rstwire_n = 1'b0;
        #3;
        checks++;
        if ({id_valid, fif.jump_selector, halted} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got %b want 000", {id_valid, fif.jump_selector, halted});
        end
        checks++;
        if ({id_instruction, id_npc, fif.jump_address} !== 36'h0) begin
            errors++;
            $display("FAIL reset_regs got %h want 0", {id_instruction, id_npc, fif.jump_address});
        end
    endtask

    task automatic test_stream();
        do_reset();
        step();
        checks++;
        if ({id_valid, fif.jump_selector} !== 2'b00) begin
            errors++;
            $display("FAIL boot_edge got %b want 00", {id_valid, fif.jump_selector});
        end
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++;
            if ({id_valid, id_npc, fif.jump_selector} !== {1'b1, 8'(k), 1'b0}) begin
                errors++;
                $display("FAIL stream_%0d got v=%b npc=%h js=%b want v=1 npc=%h js=0",
                         k, id_valid, id_npc, fif.jump_selector, 8'(k));
            end
            if (k == 2) begin
                checks++;
                if ({id_opcode, id_r1, id_r2, id_imm} !== 20'h03501) begin
                    errors++;
                    $display("FAIL fields got %h want 03501", {id_opcode, id_r1, id_r2, id_imm});
                end
            end
        end
    endtask

    task automatic test_jmp();
        do_reset();
        imem[2] = 20'hC0020;
        imem[3] = 20'hF0000;   // HALT in the squash slot must be discarded
        repeat (4) step();
        checks++;
        if ({fif.jump_selector, fif.jump_address, id_valid} !== {1'b1, 8'h20, 1'b1}) begin
            errors++;
            $display("FAIL jmp_issue got js=%b ja=%h v=%b want 1 20 1",
                     fif.jump_selector, fif.jump_address, id_valid);
        end
        step();
        checks++;
        if ({id_valid, fif.jump_selector, fif.jump_address, halted, id_npc} !== {1'b0, 1'b0, 8'h20, 1'b0, 8'h04}) begin
            errors++;
            $display("FAIL jmp_squash got v=%b js=%b ja=%h h=%b npc=%h want 0 0 20 0 04",
                     id_valid, fif.jump_selector, fif.jump_address, halted, id_npc);
        end
        step();
        checks++;
        if ({id_valid, id_npc} !== {1'b1, 8'h21}) begin
            errors++;
            $display("FAIL jmp_target got v=%b npc=%h want 1 21", id_valid, id_npc);
        end
        repeat (3) step();
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL jmp_pulses got %0d want 1", pulses);
        end
    endtask

    task automatic test_jrel();
        do_reset();
        imem[5] = 20'hD00FE;
        repeat (7) step();
        checks++;
        if ({fif.jump_selector, fif.jump_address} !== {1'b1, 8'h04}) begin
            errors++;
            $display("FAIL jrel_back got js=%b ja=%h want 1 04", fif.jump_selector, fif.jump_address);
        end
        repeat (2) step();
        checks++;
        if ({id_valid, id_npc} !== {1'b1, 8'h05}) begin
            errors++;
            $display("FAIL jrel_back_tgt got v=%b npc=%h want 1 05", id_valid, id_npc);
        end
        do_reset();
        imem[0]     = 20'hC00FA;
        imem[8'hFA] = 20'hD0010;
        repeat (4) step();
        checks++;
        if ({fif.jump_selector, fif.jump_address, id_npc} !== {1'b1, 8'h0B, 8'hFB}) begin
            errors++;
            $display("FAIL jrel_wrap got js=%b ja=%h npc=%h want 1 0B FB",
                     fif.jump_selector, fif.jump_address, id_npc);
        end
        repeat (2) step();
        checks++;
        if ({id_valid, id_npc} !== {1'b1, 8'h0C}) begin
            errors++;
            $display("FAIL jrel_wrap_tgt got v=%b npc=%h want 1 0C", id_valid, id_npc);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        imem[4] = 20'hC0010;
        imem[5] = 20'hC0030;
        repeat (7) step();
        checks++;
        if ({id_valid, fif.jump_selector, fif.jump_address} !== {1'b0, 1'b0, 8'h10}) begin
            errors++;
            $display("FAIL b2b_squash got v=%b js=%b ja=%h want 0 0 10",
                     id_valid, fif.jump_selector, fif.jump_address);
        end
        step();
        checks++;
        if ({id_valid, id_npc} !== {1'b1, 8'h11}) begin
            errors++;
            $display("FAIL b2b_target got v=%b npc=%h want 1 11", id_valid, id_npc);
        end
        repeat (4) step();
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL b2b_pulses got %0d want 1", pulses);
        end
    endtask

    task automatic test_halt();
        do_reset();
        imem[7] = 20'hF0000;
        imem[8] = 20'hC0040;
        repeat (9) step();
        checks++;
        if ({id_valid, halted, id_npc, id_opcode} !== {1'b1, 1'b1, 8'h08, 4'hF}) begin
            errors++;
            $display("FAIL halt_retire got v=%b h=%b npc=%h opc=%h want 1 1 08 F",
                     id_valid, halted, id_npc, id_opcode);
        end
        repeat (2) step();
        checks++;
        if ({id_valid, halted, fif.jump_selector, id_npc, id_instruction} !== {1'b0, 1'b1, 1'b0, 8'h08, 20'hF0000}) begin
            errors++;
            $display("FAIL halt_frozen got v=%b h=%b js=%b npc=%h ir=%h want 0 1 0 08 F0000",
                     id_valid, halted, fif.jump_selector, id_npc, id_instruction);
        end
        #3 rstwire_n = 1'b0;
        #1;
        checks++;
        if ({halted, id_npc, id_instruction} !== 29'h0) begin
            errors++;
            $display("FAIL async_reset got h=%b npc=%h ir=%h want 0 00 00000",
                     halted, id_npc, id_instruction);
        end
    endtask

`ifdef IF_ID_JUMP_STATS_EN
    task automatic test_stats();
        do_reset();
        imem[8'h02] = 20'hC0010;
        imem[8'h12] = 20'hC0020;
        imem[8'h22] = 20'hD0000;   // JREL +0 still counts as a taken jump
        repeat (20) step();
        checks++;
        if ({jump_count, squash_count} !== {16'd3, 16'd3}) begin
            errors++;
            $display("FAIL stats_js got j=%0d s=%0d want 3 3", jump_count, squash_count);
        end
        checks++;
        if (valid_count !== 16'(vcount) || vcount != 16) begin
            errors++;
            $display("FAIL stats_valid got %0d want %0d (observed) and 16", valid_count, vcount);
        end
    endtask
`endif

    initial begin
        rstwire_n = 1'b0;
        fif.instructionwire = '0;
        fif.npc = '0;
        test_reset();
        test_stream();
        test_jmp();
        test_jrel();
        test_back_to_back();
        test_halt();
`ifdef IF_ID_JUMP_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
